acc_buffer: RTL and testbench

//  Decoupling stage placed directly upstream of an accelerator on an ACC_BUS link.
//  - Slave side (slv_*) faces the offloading core; master side (mst_*) faces the accelerator.
//  - Request channel (Q) is buffered in a Depth-entry FIFO.
//  - Response channel (P) is cut by a 2-entry spill register.
//  - Result: every combinational path between core and accelerator is broken, at full throughput.

---
 rtl/acc_buffer.sv | 160 ++++++++++++++++
 tb/tb_acc_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : acc_buffer
//  Brief    : ACC_BUS decoupling stage: DEPTH-entry request FIFO plus a
//             2-entry response spill register. Optional request fall-through
//             when the FIFO is empty: define ACC_BUFFER_FALLTHROUGH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_WIDTH-1:0]        slv_q_addr_i,
    input  logic [31:0]                  slv_q_data_op_i,
    input  logic [DATA_WIDTH-1:0]        slv_q_data_arga_i,
    input  logic [DATA_WIDTH-1:0]        slv_q_data_argb_i,
    input  logic [DATA_WIDTH-1:0]        slv_q_data_argc_i,
    input  logic [ID_WIDTH-1:0]          slv_q_id_i,
    input  logic                         slv_q_valid_i,
    output logic                         slv_q_ready_o,
    output logic [ADDR_WIDTH-1:0]        mst_q_addr_o,
    output logic [31:0]                  mst_q_data_op_o,
    output logic [DATA_WIDTH-1:0]        mst_q_data_arga_o,
    output logic [DATA_WIDTH-1:0]        mst_q_data_argb_o,
    output logic [DATA_WIDTH-1:0]        mst_q_data_argc_o,
    output logic [ID_WIDTH-1:0]          mst_q_id_o,
    output logic                         mst_q_valid_o,
    input  logic                         mst_q_ready_i,
    input  logic [DATA_WIDTH-1:0]        mst_p_data_i,
    input  logic [ID_WIDTH-1:0]          mst_p_id_i,
    input  logic                         mst_p_error_i,
    input  logic                         mst_p_valid_i,
    output logic                         mst_p_ready_o,
    output logic [DATA_WIDTH-1:0]        slv_p_data_o,
    output logic [ID_WIDTH-1:0]          slv_p_id_o,
    output logic                         slv_p_error_o,
    output logic                         slv_p_valid_o,
    input  logic                         slv_p_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   q_usage_o
);

    localparam int c_q_w     = ADDR_WIDTH + 32 + 3 * DATA_WIDTH + ID_WIDTH;
    localparam int c_p_w     = DATA_WIDTH + ID_WIDTH + 1;
    localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_usage_w = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [c_q_w-1:0]     r_q_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_q_wptr;
    logic [c_ptr_w-1:0]   r_q_rptr;
    logic [c_usage_w-1:0] r_q_usage;
    logic [c_q_w-1:0]     w_q_in;
    logic [c_q_w-1:0]     w_q_head;
    logic [c_q_w-1:0]     w_q_out;
    logic                 w_q_empty;
    logic                 w_q_full;
    logic                 w_q_push;
    logic                 w_q_pop;

    function automatic logic [c_ptr_w-1:0] f_ptr_next(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(DEPTH - 1)) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    assign w_q_in    = {slv_q_addr_i, slv_q_data_op_i, slv_q_data_arga_i,
                        slv_q_data_argb_i, slv_q_data_argc_i, slv_q_id_i};
    assign w_q_head  = r_q_mem[r_q_rptr];
    assign w_q_empty = (r_q_usage == '0);
    assign w_q_full  = (r_q_usage == c_usage_w'(DEPTH));

    // Ready depends only on the occupancy register, so a pop never re-opens a full FIFO early.
    assign slv_q_ready_o = !w_q_full;
    assign w_q_pop       = !w_q_empty && mst_q_ready_i;

`ifdef ACC_BUFFER_FALLTHROUGH_EN
    logic w_q_bypass;
    assign w_q_bypass    = w_q_empty && slv_q_valid_i;
    assign mst_q_valid_o = !w_q_empty || slv_q_valid_i;
    assign w_q_out       = w_q_bypass ? w_q_in : w_q_head;
    assign w_q_push      = slv_q_valid_i && !w_q_full && !(w_q_bypass && mst_q_ready_i);
`else
    assign mst_q_valid_o = !w_q_empty;
    assign w_q_out       = w_q_head;
    assign w_q_push      = slv_q_valid_i && !w_q_full;
`endif

    assign {mst_q_addr_o, mst_q_data_op_o, mst_q_data_arga_o,
            mst_q_data_argb_o, mst_q_data_argc_o, mst_q_id_o} = w_q_out;
    assign q_usage_o = r_q_usage;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_mem[i] <= '0;
            end
            r_q_wptr  <= '0;
            r_q_rptr  <= '0;
            r_q_usage <= '0;
        end else begin
            if (w_q_push) begin
                r_q_mem[r_q_wptr] <= w_q_in;
                r_q_wptr          <= f_ptr_next(r_q_wptr);
            end
            if (w_q_pop) begin
                r_q_rptr <= f_ptr_next(r_q_rptr);
            end
            unique case ({w_q_push, w_q_pop})
                2'b10:   r_q_usage <= r_q_usage + c_usage_w'(1);
                2'b01:   r_q_usage <= r_q_usage - c_usage_w'(1);
                default: r_q_usage <= r_q_usage;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response spill register: two slots used as a tiny ring buffer
    // ------------------------------------------------------------------
    logic [c_p_w-1:0] r_p_mem [2];
    logic             r_p_wptr;
    logic             r_p_rptr;
    logic [1:0]       r_p_cnt;
    logic             w_p_push;
    logic             w_p_pop;

    assign mst_p_ready_o = (r_p_cnt != 2'd2);
    assign slv_p_valid_o = (r_p_cnt != 2'd0);
    assign w_p_push      = mst_p_valid_i && mst_p_ready_o;
    assign w_p_pop       = slv_p_valid_o && slv_p_ready_i;
    assign {slv_p_data_o, slv_p_id_o, slv_p_error_o} = r_p_mem[r_p_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p_mem[0] <= '0;
            r_p_mem[1] <= '0;
            r_p_wptr   <= 1'b0;
            r_p_rptr   <= 1'b0;
            r_p_cnt    <= 2'd0;
        end else begin
            if (w_p_push) begin
                r_p_mem[r_p_wptr] <= {mst_p_data_i, mst_p_id_i, mst_p_error_i};
                r_p_wptr          <= !r_p_wptr;
            end
            if (w_p_pop) begin
                r_p_rptr <= !r_p_rptr;
            end
            unique case ({w_p_push, w_p_pop})
                2'b10:   r_p_cnt <= r_p_cnt + 2'd1;
                2'b01:   r_p_cnt <= r_p_cnt - 2'd1;
                default: r_p_cnt <= r_p_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_buffer
//  Brief    : Self-checking bench for acc_buffer (DEPTH=2 and DEPTH=3 instances),
//             queue-level reference model plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_buffer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 4;
`ifdef ACC_BUFFER_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif
    localparam int LAT = FT ? 0 : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [IW-1:0] id;
    } qpkt_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
    } ppkt_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qpkt_t         sq       [2];
    logic          sq_valid [2];
    logic          sq_ready [2];
    logic [AW-1:0] mq_addr  [2];
    logic [31:0]   mq_op    [2];
    logic [DW-1:0] mq_a     [2];
    logic [DW-1:0] mq_b     [2];
    logic [DW-1:0] mq_c     [2];
    logic [IW-1:0] mq_id    [2];
    logic          mq_valid [2];
    logic          mq_ready [2];
    logic [DW-1:0] mp_data  [2];
    logic [IW-1:0] mp_id    [2];
    logic          mp_err   [2];
    logic          mp_valid [2];
    logic          mp_ready [2];
    logic [DW-1:0] sp_data  [2];
    logic [IW-1:0] sp_id    [2];
    logic          sp_err   [2];
    logic          sp_valid [2];
    logic          sp_ready [2];
    logic [1:0]    usage    [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        acc_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(2 + d)) u_dut (
            .clk_i             (clk),
            .rst_ni            (rst_n),
            .slv_q_addr_i      (sq[d].addr),
            .slv_q_data_op_i   (sq[d].op),
            .slv_q_data_arga_i (sq[d].a),
            .slv_q_data_argb_i (sq[d].b),
            .slv_q_data_argc_i (sq[d].c),
            .slv_q_id_i        (sq[d].id),
            .slv_q_valid_i     (sq_valid[d]),
            .slv_q_ready_o     (sq_ready[d]),
            .mst_q_addr_o      (mq_addr[d]),
            .mst_q_data_op_o   (mq_op[d]),
            .mst_q_data_arga_o (mq_a[d]),
            .mst_q_data_argb_o (mq_b[d]),
            .mst_q_data_argc_o (mq_c[d]),
            .mst_q_id_o        (mq_id[d]),
            .mst_q_valid_o     (mq_valid[d]),
            .mst_q_ready_i     (mq_ready[d]),
            .mst_p_data_i      (mp_data[d]),
            .mst_p_id_i        (mp_id[d]),
            .mst_p_error_i     (mp_err[d]),
            .mst_p_valid_i     (mp_valid[d]),
            .mst_p_ready_o     (mp_ready[d]),
            .slv_p_data_o      (sp_data[d]),
            .slv_p_id_o        (sp_id[d]),
            .slv_p_error_o     (sp_err[d]),
            .slv_p_valid_o     (sp_valid[d]),
            .slv_p_ready_i     (sp_ready[d]),
            .q_usage_o         (usage[d])
        );
    end

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    qpkt_t mq_m   [2][$];
    ppkt_t mp_m   [2][$];
    int    out_id [2][$];
    int    out_cyc[2][$];
    int    in_cyc [2][$];
    ppkt_t plog   [2][$];

    task automatic chk(input int d, input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h", d, name, act, exp);
        end
    endtask

    function automatic qpkt_t mk_q(input int id);
        qpkt_t p;
        p.addr = AW'(id + 1);
        p.op   = 32'hC0DE_0000 + 32'(id);
        p.a    = DW'(id * 7 + 3);
        p.b    = ~DW'(id);
        p.c    = DW'(id) << 16;
        p.id   = IW'(id);
        return p;
    endfunction

    // Reference model: plain queues with capacity DEPTH (Q) and 2 (P)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mq_m[d].delete();
                mp_m[d].delete();
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin : m_upd
                int sz;
                int psz;
                bit ft;
                sz  = mq_m[d].size();
                psz = mp_m[d].size();
                ft  = FT && (sz == 0) && sq_valid[d];
                if (sz != 0 && mq_ready[d]) void'(mq_m[d].pop_front());
                if (sq_valid[d] && sz != 2 + d && !(ft && mq_ready[d])) mq_m[d].push_back(sq[d]);
                if (psz != 0 && sp_ready[d]) void'(mp_m[d].pop_front());
                if (mp_valid[d] && psz != 2) mp_m[d].push_back({mp_data[d], mp_id[d], mp_err[d]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin : m_cmp
                int    sz;
                int    psz;
                bit    ft;
                qpkt_t exp_q;
                sz  = mq_m[d].size();
                psz = mp_m[d].size();
                ft  = FT && (sz == 0) && sq_valid[d];
                chk(d, "q_ready", sq_ready[d], sz != 2 + d);
                chk(d, "q_usage", usage[d], sz);
                chk(d, "q_valid", mq_valid[d], (sz != 0) || ft);
                if (sz != 0 || ft) begin
                    exp_q = ft ? sq[d] : mq_m[d][0];
                    chk(d, "q_fields", {mq_addr[d], mq_op[d], mq_a[d], mq_b[d], mq_c[d], mq_id[d]}, exp_q);
                end
                chk(d, "p_ready", mp_ready[d], psz != 2);
                chk(d, "p_valid", sp_valid[d], psz != 0);
                if (psz != 0) chk(d, "p_fields", {sp_data[d], sp_id[d], sp_err[d]}, mp_m[d][0]);
                if (sq_valid[d] && sq_ready[d]) in_cyc[d].push_back(cyc);
                if (mq_valid[d] && mq_ready[d]) begin
                    out_id[d].push_back(int'(mq_id[d]));
                    out_cyc[d].push_back(cyc);
                end
                if (sp_valid[d] && sp_ready[d]) plog[d].push_back({sp_data[d], sp_id[d], sp_err[d]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present request id on dut d and hold it until accepted
    task automatic send_q(input int d, input int id);
        bit hs;
        hs       = 1'b0;
        sq[d]    = mk_q(id);
        sq_valid[d] = 1'b1;
        for (int k = 0; k < 60 && !hs; k++) begin
            @(negedge clk);
            hs = sq_ready[d];
            tick();
        end
        if (!hs) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d send_timeout: got no handshake expected handshake for id %0d", d, id);
        end
    endtask

    task automatic reset_chk(input int d);
        chk(d, "rst_q_valid", mq_valid[d], 1'b0);
        chk(d, "rst_p_valid", sp_valid[d], 1'b0);
        chk(d, "rst_usage", usage[d], 0);
        chk(d, "rst_q_ready", sq_ready[d], 1'b1);
        chk(d, "rst_p_ready", mp_ready[d], 1'b1);
        chk(d, "rst_q_fields", {mq_addr[d], mq_op[d], mq_a[d], mq_b[d], mq_c[d], mq_id[d]}, 0);
        chk(d, "rst_p_fields", {sp_data[d], sp_id[d], sp_err[d]}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int max_use;
        for (int d = 0; d < 2; d++) begin
            sq[d] = '0; sq_valid[d] = 0; mq_ready[d] = 0;
            mp_data[d] = '0; mp_id[d] = '0; mp_err[d] = 0; mp_valid[d] = 0; sp_ready[d] = 0;
        end
        #2;
        reset_chk(0);
        reset_chk(1);
        #10 rst_n = 1'b1;
        tick();

        // Fill DEPTH=2 FIFO while stalled, id 3 must wait
        send_q(0, 1);
        send_q(0, 2);
        sq[0] = mk_q(3);
        @(negedge clk);
        chk(0, "t2_ready_full", sq_ready[0], 1'b0);
        chk(0, "t2_usage", usage[0], 2);
        chk(0, "t2_head_id", mq_id[0], 1);
        tick();
        @(negedge clk);
        chk(0, "t2_stall_op", mq_op[0], 32'hC0DE_0001);
        tick();
        out_id[0].delete();
        mq_ready[0] = 1'b1;
        send_q(0, 3);
        sq_valid[0] = 1'b0;
        repeat (3) tick();
        chk(0, "t2_count", out_id[0].size(), 3);
        for (int i = 0; i < out_id[0].size(); i++) chk(0, "t2_order", out_id[0][i], i + 1);

        // Back-to-back streaming
        out_id[0].delete(); out_cyc[0].delete(); in_cyc[0].delete();
        for (int i = 0; i < 8; i++) send_q(0, 8 + i);
        sq_valid[0] = 1'b0;
        repeat (3) tick();
        chk(0, "t3_count", out_id[0].size(), 8);
        for (int i = 0; i < 8 && i < out_id[0].size() && i < in_cyc[0].size(); i++) begin
            chk(0, "t3_id", out_id[0][i], 8 + i);
            chk(0, "t3_latency", out_cyc[0][i] - in_cyc[0][i], LAT);
            chk(0, "t3_gapless", out_cyc[0][i] - out_cyc[0][0], i);
        end

        // Response spill register under backpressure
        plog[0].delete();
        mp_data[0] = 32'h5555_0005; mp_id[0] = 4'd5; mp_err[0] = 1'b1; mp_valid[0] = 1'b1;
        tick();
        mp_data[0] = 32'h6666_0006; mp_id[0] = 4'd6; mp_err[0] = 1'b0;
        tick();
        mp_valid[0] = 1'b0;
        @(negedge clk);
        chk(0, "t4_p_ready_full", mp_ready[0], 1'b0);
        chk(0, "t4_head_id", sp_id[0], 5);
        chk(0, "t4_head_err", sp_err[0], 1'b1);
        tick();
        sp_ready[0] = 1'b1;
        repeat (3) tick();
        chk(0, "t4_count", plog[0].size(), 2);
        if (plog[0].size() == 2) begin
            chk(0, "t4_first", plog[0][0], {32'h5555_0005, 4'd5, 1'b1});
            chk(0, "t4_second", plog[0][1], {32'h6666_0006, 4'd6, 1'b0});
        end

        // Reset in the middle of traffic
        mq_ready[0] = 1'b0;
        send_q(0, 10);
        send_q(0, 11);
        sq_valid[0] = 1'b0;
        mp_id[0] = 4'd7; mp_data[0] = 32'h7; mp_valid[0] = 1'b1;
        tick();
        mp_valid[0] = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        reset_chk(0);
        reset_chk(1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        out_id[0].delete();
        mq_ready[0] = 1'b1;
        send_q(0, 12);
        sq_valid[0] = 1'b0;
        repeat (2) tick();
        chk(0, "t1_count", out_id[0].size(), 1);
        if (out_id[0].size() == 1) chk(0, "t1_clean_id", out_id[0][0], 12);

        // Latency from an empty FIFO with the accelerator ready
        sq[0] = mk_q(9);
        sq_valid[0] = 1'b1;
        @(negedge clk);
        chk(0, "t6_valid_same", mq_valid[0], FT);
        chk(0, "t6_usage_same", usage[0], 0);
        tick();
        sq_valid[0] = 1'b0;
        @(negedge clk);
        chk(0, "t6_valid_next", mq_valid[0], !FT);
        chk(0, "t6_usage_next", usage[0], FT ? 0 : 1);
        repeat (2) tick();

        // DEPTH=3 with random stalls on both sides across pointer wrap
        out_id[1].delete();
        max_use = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    sq_valid[1] = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                    send_q(1, i % 16);
                end
                sq_valid[1] = 1'b0;
            end
            begin
                for (int k = 0; k < 600 && out_id[1].size() < 20; k++) begin
                    mq_ready[1] = ($urandom_range(0, 2) == 0);
                    tick();
                    if (int'(usage[1]) > max_use) max_use = int'(usage[1]);
                end
                mq_ready[1] = 1'b0;
            end
        join
        chk(1, "t5_count", out_id[1].size(), 20);
        chk(1, "t5_max_usage_le3", max_use <= 3, 1'b1);
        for (int i = 0; i < out_id[1].size(); i++) chk(1, "t5_order", out_id[1][i], i % 16);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
